// File: rtl/count_step_checker.sv
// Monitor for the programmable step counter: checks each sampled step against the mode, counts wraps and errors.
// Latency 1 cycle from sampling edge to outputs; no backpressure, accepts one sample per cycle.
module count_step_checker #(
  parameter int WIDTH   = 8,
  parameter int STEP_HI = 2,
  parameter int STEP_LO = 3,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] num_in,
  input  logic             ac_dc,
  input  logic             clr,
  output logic [WIDTH-1:0] delta,
  output logic             step_ok,
  output logic             step_err,
  output logic             fault,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             hist_valid
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Steps are compared after truncation to the counter width.
  localparam logic [WIDTH-1:0] EXP_HI  = WIDTH'(STEP_HI);
  localparam logic [WIDTH-1:0] EXP_LO  = WIDTH'(STEP_LO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx;
  logic [WIDTH-1:0] delta_nx;
  logic             ok_nx, err_nx;
  logic [CNT_W-1:0] wrap_nx, errc_nx;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] exp_step;
  logic             wrapped;

  assign diff     = num_in - prev;
  assign exp_step = ac_dc ? EXP_HI : EXP_LO;
  assign wrapped  = (num_in < prev);

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    delta_nx = delta;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    wrap_nx  = wrap_cnt;
    errc_nx  = err_cnt;

    if (clr) begin
      // clr wins over a coincident sample, which is dropped.
      state_nx = EMPTY;
      prev_nx  = '0;
      delta_nx = '0;
      wrap_nx  = '0;
      errc_nx  = '0;
    end else if (sample_en) begin
      unique case (state)
        EMPTY: begin
          prev_nx  = num_in;
          state_nx = TRACK;
        end
        TRACK, FAULT: begin
          delta_nx = diff;
          prev_nx  = num_in;
          if (diff == exp_step) begin
            ok_nx = 1'b1;
          end else begin
            err_nx   = 1'b1;
            state_nx = FAULT;
            if (err_cnt != CNT_MAX) errc_nx = err_cnt + CNT_W'(1);
          end
          // Wrap is judged independently of step correctness.
          if (wrapped && (wrap_cnt != CNT_MAX)) wrap_nx = wrap_cnt + CNT_W'(1);
        end
        default: begin
          state_nx = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= EMPTY;
      prev       <= '0;
      delta      <= '0;
      step_ok    <= 1'b0;
      step_err   <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
      fault      <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      delta      <= delta_nx;
      step_ok    <= ok_nx;
      step_err   <= err_nx;
      wrap_cnt   <= wrap_nx;
      err_cnt    <= errc_nx;
      fault      <= (state_nx == FAULT);
      hist_valid <= (state_nx != EMPTY);
    end
  end

endmodule

// File: tb/tb_count_step_checker.sv
// Directed bench for count_step_checker: reference model fills an expectation queue, popped after each edge.
module tb_count_step_checker;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] num_in = 8'd0;
  logic       ac_dc = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] delta;
  logic       step_ok, step_err, fault, hist_valid;
  logic [7:0] wrap_cnt, err_cnt;

  count_step_checker #(.WIDTH(8), .STEP_HI(2), .STEP_LO(3), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .sample_en(sample_en), .num_in(num_in),
    .ac_dc(ac_dc), .clr(clr), .delta(delta), .step_ok(step_ok),
    .step_err(step_err), .fault(fault), .wrap_cnt(wrap_cnt),
    .err_cnt(err_cnt), .hist_valid(hist_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] delta;
    logic       ok;
    logic       err;
    logic       fault;
    logic [7:0] wrap;
    logic [7:0] errc;
    logic       hv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: 0 empty, 1 tracking, 2 fault.
  int         m_state = 0;
  logic [7:0] m_prev = 0, m_delta = 0, m_wrap = 0, m_errc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_delta = 0; m_wrap = 0; m_errc = 0;
  endtask

  task automatic push_model(input logic en, input logic [7:0] n, input logic ad, input logic c);
    exp_t e;
    logic [7:0] d, stp;
    e.ok = 1'b0;
    e.err = 1'b0;
    if (c) begin
      model_reset();
    end else if (en) begin
      if (m_state == 0) begin
        m_prev = n;
        m_state = 1;
      end else begin
        d = n - m_prev;
        stp = ad ? 8'd2 : 8'd3;
        m_delta = d;
        if (d == stp) e.ok = 1'b1;
        else begin
          e.err = 1'b1;
          m_state = 2;
          if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        end
        if (n < m_prev && m_wrap != 8'hFF) m_wrap = m_wrap + 8'd1;
        m_prev = n;
      end
    end
    e.delta = m_delta;
    e.fault = (m_state == 2);
    e.wrap = m_wrap;
    e.errc = m_errc;
    e.hv = (m_state != 0);
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_delta"}, delta, e.delta);
    chk({tag, "_ok"}, step_ok, e.ok);
    chk({tag, "_err"}, step_err, e.err);
    chk({tag, "_fault"}, fault, e.fault);
    chk({tag, "_wrap"}, wrap_cnt, e.wrap);
    chk({tag, "_errcnt"}, err_cnt, e.errc);
    chk({tag, "_hv"}, hist_valid, e.hv);
  endtask

  task automatic cycle(input string tag, input logic en, input logic [7:0] n,
                       input logic ad, input logic c);
    @(negedge CLK);
    sample_en = en; num_in = n; ac_dc = ad; clr = c;
    push_model(en, n, ad, c);
    @(posedge CLK);
    #1;
    sample_en = 1'b0; clr = 1'b0;
    pop_compare(tag);
  endtask

  initial begin
    // Reset state, held asynchronously.
    #2;
    model_reset();
    push_model(1'b0, 8'd0, 1'b0, 1'b0);
    pop_compare("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Stride 3 from 0.
    cycle("s3_cap", 1, 8'd0, 0, 0);
    chk("s3_cap_hv", hist_valid, 1);
    cycle("s3_a", 1, 8'd3, 0, 0);
    cycle("s3_b", 1, 8'd6, 0, 0);
    cycle("s3_c", 1, 8'd9, 0, 0);
    chk("s3_delta", delta, 3);
    cycle("idle", 0, 8'd77, 1, 0);
    chk("idle_delta_hold", delta, 3);

    // Stride 2 across the wrap, then a full lap back to a stride-3 wrap.
    cycle("clr1", 0, 8'd0, 0, 1);
    cycle("w_cap", 1, 8'd252, 1, 0);
    cycle("w_a", 1, 8'd254, 1, 0);
    cycle("w_b", 1, 8'd0, 1, 0);
    chk("w_wrap1", wrap_cnt, 1);
    for (int v = 2; v <= 254; v += 2) cycle("lap", 1, 8'(v), 1, 0);
    cycle("w_c", 1, 8'd1, 0, 0);
    chk("w_wrap2", wrap_cnt, 2);
    chk("w_ok2", step_ok, 1);

    // Step error enters FAULT, which is sticky across good steps.
    cycle("clr2", 0, 8'd0, 0, 1);
    cycle("e_cap", 1, 8'd6, 1, 0);
    cycle("e_bad", 1, 8'd10, 1, 0);
    chk("e_delta4", delta, 4);
    chk("e_fault", fault, 1);
    cycle("e_good", 1, 8'd12, 1, 0);
    chk("e_fault_sticky", fault, 1);

    // clr beats a coincident sample; next sample is capture only.
    cycle("clr_s", 1, 8'd50, 0, 1);
    chk("clr_hv", hist_valid, 0);
    cycle("clr_cap", 1, 8'd53, 0, 0);
    chk("clr_cap_ok", step_ok, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) cycle("sat", 1, 8'(53 + 5 * (i + 1)), 0, 0);
    chk("sat_errcnt", err_cnt, 255);

    // Build wrap_cnt=3 in FAULT, then reset asynchronously mid-cycle.
    cycle("clr3", 0, 8'd0, 0, 1);
    cycle("r_cap", 1, 8'd250, 0, 0);
    cycle("r1", 1, 8'd251, 0, 0);
    cycle("r2", 1, 8'd0, 0, 0);
    cycle("r3", 1, 8'd255, 0, 0);
    cycle("r4", 1, 8'd1, 0, 0);
    cycle("r5", 1, 8'd255, 0, 0);
    cycle("r6", 1, 8'd2, 0, 0);
    chk("r_wrap3", wrap_cnt, 3);
    chk("r_fault", fault, 1);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    push_model(1'b0, 8'd0, 1'b0, 1'b0);
    pop_compare("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    cycle("pr_cap", 1, 8'd100, 0, 0);
    chk("pr_cap_err", step_err, 0);
    cycle("pr_a", 1, 8'd103, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_step_checker.md
# count_step_checker

Downstream consumer of the programmable step counter. On each sample strobe it takes the counter's 8-bit output together with the `ac_dc` mode that produced it, and checks that the value advanced by exactly the selected step (2 when `ac_dc`=1, 3 when `ac_dc`=0), modulo 2^WIDTH. It also counts wrap-arounds and step errors, and holds a sticky fault state. It sits between the counter and the bench/status logic as a self-checking monitor stage.

## Interface
- WIDTH, 8, width of the counter value and of `delta`
- STEP_HI, 2, expected increment when `ac_dc`=1
- STEP_LO, 3, expected increment when `ac_dc`=0
- CNT_W, 8, width of the `wrap_cnt` and `err_cnt` statistics counters
- CLK  input  1  clock; all state updates on posedge
- RST_N  input  1  asynchronous, active-low reset
- sample_en  input  1  when 1, `num_in`/`ac_dc` are sampled this cycle
- num_in  input  WIDTH  counter value after its step
- ac_dc  input  1  mode that produced `num_in` (1 → STEP_HI, 0 → STEP_LO)
- clr  input  1  synchronous clear of history, statistics and fault
- delta  output  WIDTH  registered (num_in − prev) mod 2^WIDTH
- step_ok  output  1  one-cycle pulse: last checked step matched
- step_err  output  1  one-cycle pulse: last checked step mismatched
- fault  output  1  sticky; 1 while the FSM is in FAULT
- wrap_cnt  output  CNT_W  number of observed wrap-arounds, saturating
- err_cnt  output  CNT_W  number of step mismatches, saturating
- hist_valid  output  1  a previous sample is held (state ≠ EMPTY)

## Operation
- Internal `prev` register (WIDTH) holds the last sampled `num_in`.
- FSM states: EMPTY, TRACK, FAULT.
- EMPTY, sample_en=1: `prev`←num_in; go to TRACK; no check; `delta`, `step_ok`, `step_err` stay 0.
- TRACK/FAULT, sample_en=1:
  - d = (num_in − prev) mod 2^WIDTH; `delta`←d.
  - exp = ac_dc ? STEP_HI : STEP_LO.
  - d==exp: pulse `step_ok`.
  - d≠exp: pulse `step_err`; `err_cnt`+1, saturating at 2^CNT_W−1; TRACK→FAULT.
  - num_in < prev (unsigned): `wrap_cnt`+1, saturating. The wrap check is independent of the step check, so a bad step that wraps counts in both.
  - `prev`←num_in.
- FAULT is left only by clr or reset; checking and counting continue while in FAULT.
- sample_en=0: no state changes; `step_ok`/`step_err` return to 0; `delta` holds.
- clr=1: state→EMPTY; `prev`, `delta`, `wrap_cnt`, `err_cnt` ←0; pulses 0. clr has priority over a simultaneous sample_en, and that sample is dropped.
- Arithmetic is unsigned and truncated to WIDTH. Steps are compared after truncation, so STEP values must be < 2^WIDTH.

## Timing
- Reset (RST_N=0, asynchronous) sets all outputs to 0 immediately and the state to EMPTY. This covers `delta`, `step_ok`, `step_err`, `fault`, `wrap_cnt`, `err_cnt`, `hist_valid`, and `prev`.
- Release of reset is synchronous to the design. The first posedge with RST_N=1 is a normal cycle.
- All outputs are registered, with a latency of 1 cycle from sampling edge to visible result.
- `step_ok`/`step_err` are high for exactly one cycle per checked sample and are never high together.
- `fault` and `hist_valid` follow the state register and update on the same edge as the check that changes them.
- Back-to-back samples (sample_en held high) are supported at one check per cycle.
- Reset asserted mid-stream discards history. The next sample after release is an EMPTY capture and is not checked.

## Test plan
- Reset, then sample 0,3,6,9 with ac_dc=0 → first sample gives no pulse and hist_valid=1; then three `step_ok` pulses, delta=3, err_cnt=0, fault=0.
- Sample 252, 254, 0 with ac_dc=1 → two `step_ok`; final delta=2, wrap_cnt=1. Then 254→1 with ac_dc=0 → `step_ok`, wrap_cnt=2.
- Sample 6 then 10 with ac_dc=1 → delta=4, `step_err` pulse, err_cnt=1, fault=1. Then 12 with ac_dc=1 → `step_ok`, fault stays 1.
- In FAULT, assert clr together with sample_en (num_in=50) → next cycle: state EMPTY, fault=0, counters 0, hist_valid=0; the next sample is capture-only.
- Drive 300 mismatching samples → err_cnt saturates at 255 and never wraps to 0.
- Assert RST_N=0 mid-cycle while fault=1 and wrap_cnt=3 → outputs go to 0 before the next edge; after release the first sample is unchecked.
